util_cpack2_timestamp_insert: RTL and testbench

Receive-path timestamp inserter between the ADC channel packer (util_cpack2) and the RX DMA write port. Every `timestamp_every` packed 64-bit data words, it inserts one 64-bit word holding the sample timestamp of the first word in that group. This produces the interleaved timestamp/data stream format that the TX path consumes. It operates in the ADC clock domain and buffers internally to absorb the extra output slot and DMA backpressure.

---
 rtl/util_cpack2_timestamp_insert.sv | 160 ++++++++++++++++
 tb/tb_util_cpack2_timestamp_insert.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/util_cpack2_timestamp_insert.sv
// util_cpack2_timestamp_insert
// Interleaves a sample timestamp ahead of every group of packed RX words.
module util_cpack2_timestamp_insert #(
    parameter int DATA_WIDTH      = 64,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] timestamp,
    input  logic [31:0]           timestamp_every,
    input  logic                  xfer_req,
    input  logic                  s_axis_valid,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  overflow
);
    localparam int L     = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << L;
    localparam logic [L:0] PTR_ONE = {{L{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, TS, DATA} state_t;

    typedef struct packed {
        logic                  has_ts;
        logic [DATA_WIDTH-1:0] ts;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                mem [DEPTH];
    entry_t                wr_entry;
    entry_t                head;
    logic [L:0]            wr_ptr;
    logic [L:0]            rd_ptr;
    logic [31:0]           group_cnt;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  group_start;
    logic                  load;
    state_t                state;
    state_t                state_n;
    logic                  valid_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic [DATA_WIDTH-1:0] held;
    logic [DATA_WIDTH-1:0] held_n;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[L] != rd_ptr[L]) &&
                   (wr_ptr[L-1:0] == rd_ptr[L-1:0]);
    assign head  = mem[rd_ptr[L-1:0]];

    // A same-cycle pop frees the slot the incoming word needs.
    assign push = s_axis_valid && xfer_req && (!full || pop);
    assign drop = s_axis_valid && xfer_req && full && !pop;

    assign group_start = (group_cnt == 32'd0) &&
                         (timestamp_every != 32'd0);
    assign wr_entry = '{has_ts: group_start,
                        ts:     timestamp,
                        data:   s_axis_data};

    // Entry storage; contents only matter between the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[L-1:0]] <= wr_entry;
    end

    // FIFO pointers, one extra bit to tell full from empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Group counter; a drop or a stopped transfer restarts grouping.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            group_cnt <= '0;
        end else if (!xfer_req || drop) begin
            group_cnt <= '0;
        end else if (push) begin
            if (group_cnt == 32'd0)
                group_cnt <= (timestamp_every == 32'd0) ? 32'd0
                           : timestamp_every - 32'd1;
            else
                group_cnt <= group_cnt - 32'd1;
        end
    end

    // Registered one-cycle pulse for each dropped word.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) overflow <= 1'b0;
        else         overflow <= drop;
    end

    // Output sequencing: timestamp word first, then its data word.
    always_comb begin
        state_n = state;
        valid_n = m_axis_valid;
        data_n  = m_axis_data;
        held_n  = held;
        pop     = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: load = !empty;
            TS: begin
                if (m_axis_ready) begin
                    data_n  = held;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (m_axis_ready) begin
                    if (!empty) begin
                        load = 1'b1;
                    end else begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        if (load) begin
            pop     = 1'b1;
            valid_n = 1'b1;
            if (head.has_ts) begin
                state_n = TS;
                data_n  = head.ts;
                held_n  = head.data;
            end else begin
                state_n = DATA;
                data_n  = head.data;
            end
        end
    end

    // Output and state registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            m_axis_valid <= 1'b0;
            m_axis_data  <= '0;
            held         <= '0;
        end else begin
            state        <= state_n;
            m_axis_valid <= valid_n;
            m_axis_data  <= data_n;
            held         <= held_n;
        end
    end

endmodule

// File: tb/tb_util_cpack2_timestamp_insert.sv
// tb_util_cpack2_timestamp_insert
// Directed checks of timestamp interleaving, overflow and reset.
module tb_util_cpack2_timestamp_insert;
    logic        clk = 1'b0;
    logic        resetn;
    logic [63:0] timestamp;
    logic [31:0] timestamp_every;
    logic        xfer_req;
    logic        s_axis_valid;
    logic [63:0] s_axis_data;
    logic        m_axis_valid;
    logic        m_axis_ready;
    logic [63:0] m_axis_data;
    logic        overflow;

    int          checks = 0;
    int          errors = 0;
    int          ovf_cnt = 0;
    logic [63:0] ts_cnt;
    logic [63:0] last_ts;
    logic [63:0] got[$];
    logic [63:0] exp_q[$];
    logic        hold_chk = 1'b0;
    logic [63:0] hold_data;

    typedef struct {
        logic        vin;
        logic [63:0] din;
        logic        ev;
        logic [63:0] ed;
    } vec_t;

    vec_t vecs[11];

    always #5 clk = ~clk;

    util_cpack2_timestamp_insert #(
        .DATA_WIDTH(64),
        .FIFO_DEPTH_LOG2(4)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .timestamp(timestamp),
        .timestamp_every(timestamp_every),
        .xfer_req(xfer_req),
        .s_axis_valid(s_axis_valid),
        .s_axis_data(s_axis_data),
        .m_axis_valid(m_axis_valid),
        .m_axis_ready(m_axis_ready),
        .m_axis_data(m_axis_data),
        .overflow(overflow)
    );

    task automatic check64(input string name, input logic [63:0] act,
                           input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Drive inputs for the next rising edge; observe registered outputs.
    task automatic step(input logic v, input logic [63:0] d,
                        input logic x, input logic r);
        @(negedge clk);
        s_axis_valid = v;
        s_axis_data  = d;
        xfer_req     = x;
        m_axis_ready = r;
        timestamp    = ts_cnt;
        last_ts      = ts_cnt;
        ts_cnt       = ts_cnt + 64'd1;
        if (hold_chk) begin
            check64("stall valid", {63'd0, m_axis_valid}, 64'd1);
            check64("stall data", m_axis_data, hold_data);
        end
        if (m_axis_valid && m_axis_ready) got.push_back(m_axis_data);
        if (overflow) ovf_cnt++;
        hold_chk  = m_axis_valid && !m_axis_ready;
        hold_data = m_axis_data;
    endtask

    // Flush queued output with the transfer stopped; bounded.
    task automatic drain(input int max);
        int idle = 0;
        for (int i = 0; i < max && idle < 3; i++) begin
            step(1'b0, 64'd0, 1'b0, 1'b1);
            if (!m_axis_valid) idle++;
            else idle = 0;
        end
        checks++;
        if (idle < 3) begin
            errors++;
            $display("FAIL drain timeout: still busy after %0d cycles", max);
        end
    endtask

    task automatic compare_seq(input string name);
        int n;
        check64({name, " length"}, 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check64($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int s = 0; s < 11; s++) begin
            vecs[s].vin = (s < 8);
            vecs[s].din = 64'(s + 1);
            vecs[s].ev  = (s >= 2) && (s <= 9);
            vecs[s].ed  = 64'(s - 1);
        end

        resetn          = 1'b0;
        timestamp       = '0;
        timestamp_every = '0;
        xfer_req        = 1'b0;
        s_axis_valid    = 1'b0;
        s_axis_data     = '0;
        m_axis_ready    = 1'b0;
        ts_cnt          = 64'd1000;
        #12;
        check64("reset valid", {63'd0, m_axis_valid}, 64'd0);
        check64("reset data", m_axis_data, 64'd0);
        check64("reset overflow", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Insertion off: back-to-back pass-through, one cycle latency.
        ovf_cnt = 0;
        for (int s = 0; s < 11; s++) begin
            step(vecs[s].vin, vecs[s].din, 1'b1, 1'b1);
            check64($sformatf("passthru valid s%0d", s),
                    {63'd0, m_axis_valid}, {63'd0, vecs[s].ev});
            if (vecs[s].ev)
                check64($sformatf("passthru data s%0d", s),
                        m_axis_data, vecs[s].ed);
        end
        for (int w = 1; w <= 8; w++) exp_q.push_back(64'(w));
        drain(20);
        compare_seq("passthru seq");
        check64("passthru ovf", 64'(ovf_cnt), 64'd0);

        // every=4, input every other cycle.
        timestamp_every = 32'd4;
        ts_cnt = 64'd100;
        ovf_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, 64'(i / 2 + 1), 1'b1, 1'b1);
                if ((i / 2) % 4 == 0) exp_q.push_back(last_ts);
                exp_q.push_back(64'(i / 2 + 1));
            end else begin
                step(1'b0, 64'd0, 1'b1, 1'b1);
            end
        end
        drain(40);
        check64("grp4 first ts", exp_q[0], 64'd100);
        check64("grp4 second ts", exp_q[5], 64'd108);
        compare_seq("grp4 seq");
        check64("grp4 ovf", 64'(ovf_cnt), 64'd0);

        // every=4, stalled output until the FIFO overflows.
        ts_cnt = 64'd0;
        ovf_cnt = 0;
        for (int w = 1; w <= 18; w++) begin
            step(1'b1, 64'(w), 1'b1, 1'b0);
            if (w <= 17) begin
                if ((w - 1) % 4 == 0) exp_q.push_back(last_ts);
                exp_q.push_back(64'(w));
            end
        end
        repeat (3) step(1'b0, 64'd0, 1'b1, 1'b1);
        step(1'b1, 64'd19, 1'b1, 1'b1);
        exp_q.push_back(last_ts);
        exp_q.push_back(64'd19);
        drain(80);
        compare_seq("ovf seq");
        check64("ovf pulses", 64'(ovf_cnt), 64'd1);

        // Insertion off: full FIFO plus same-cycle pop accepts a word.
        timestamp_every = 32'd0;
        ovf_cnt = 0;
        for (int w = 1; w <= 17; w++) step(1'b1, 64'(w), 1'b1, 1'b0);
        for (int w = 18; w <= 24; w++) step(1'b1, 64'(w), 1'b1, 1'b1);
        for (int w = 1; w <= 24; w++) exp_q.push_back(64'(w));
        drain(60);
        compare_seq("fullpop seq");
        check64("fullpop ovf", 64'(ovf_cnt), 64'd0);

        // xfer_req drop mid-group restarts the group.
        timestamp_every = 32'd4;
        ovf_cnt = 0;
        step(1'b1, 64'd1, 1'b1, 1'b1);
        exp_q.push_back(last_ts);
        exp_q.push_back(64'd1);
        step(1'b1, 64'd2, 1'b1, 1'b1);
        exp_q.push_back(64'd2);
        repeat (5) step(1'b1, 64'hDEAD, 1'b0, 1'b1);
        step(1'b1, 64'd3, 1'b1, 1'b1);
        exp_q.push_back(last_ts);
        exp_q.push_back(64'd3);
        step(1'b1, 64'd4, 1'b1, 1'b1);
        exp_q.push_back(64'd4);
        drain(40);
        compare_seq("xfer seq");
        check64("xfer ovf", 64'(ovf_cnt), 64'd0);

        // Asynchronous reset with output busy and 5 queued entries.
        timestamp_every = 32'd0;
        for (int w = 1; w <= 6; w++) step(1'b1, 64'(w), 1'b1, 1'b0);
        step(1'b0, 64'd0, 1'b1, 1'b0);
        check64("pre-reset valid", {63'd0, m_axis_valid}, 64'd1);
        check64("pre-reset nothing sent", 64'(got.size()), 64'd0);
        #3;
        resetn = 1'b0;
        #1;
        check64("async reset valid", {63'd0, m_axis_valid}, 64'd0);
        check64("async reset data", m_axis_data, 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn   = 1'b1;
        hold_chk = 1'b0;
        got.delete();
        ovf_cnt = 0;
        timestamp_every = 32'd2;
        step(1'b1, 64'hA, 1'b1, 1'b1);
        exp_q.push_back(last_ts);
        exp_q.push_back(64'hA);
        step(1'b1, 64'hB, 1'b1, 1'b1);
        exp_q.push_back(64'hB);
        drain(40);
        compare_seq("post-reset seq");

        // every=1 with timestamp wrapping through zero.
        timestamp_every = 32'd1;
        ts_cnt = 64'hFFFF_FFFF_FFFF_FFF0;
        ovf_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                step(1'b1, 64'hA000 + 64'(i), 1'b1, 1'b1);
                exp_q.push_back(last_ts);
                exp_q.push_back(64'hA000 + 64'(i));
            end else begin
                step(1'b0, 64'd0, 1'b1, 1'b1);
            end
        end
        drain(40);
        compare_seq("every1 seq");
        check64("every1 ovf", 64'(ovf_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
